spu_issue_ctrl: RTL and testbench

- Dual-issue control stage directly upstream of the ID/REG pipeline register.
- Accepts a decoded instruction pair (slot 0 older, slot 1 younger) from the instruction decoder into a one-pair buffer.
- Resolves RAW/WAW hazards against a per-register latency scoreboard and even/odd pipe conflicts, then routes issued instructions to the _ID1 (even) and _ID2 (odd) inputs of the ID/REG register. Non-issued outputs are driven as bubbles.

---
 rtl/spu_pkg.sv | 42 ++++
 rtl/spu_scoreboard.sv | 64 ++++++
 rtl/spu_issue_ctrl.sv | 176 +++++++++++++++++
 tb/tb_spu_issue_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spu_pkg.sv
// spu_pkg: shared types and sizes for the SPU issue stage.
//   NREG / REG_W : architectural register count and specifier width
//   LAT_W        : width of the latency field and scoreboard countdowns
//   PIPE_EVEN/ODD: values of dec_instr_t.pipe
//   dec_instr_t  : decoded instruction as delivered by the decoder
//   state_e      : issue buffer occupancy
package spu_pkg;

  localparam int unsigned NREG  = 128;
  localparam int unsigned REG_W = 7;
  localparam int unsigned LAT_W = 4;

  localparam logic PIPE_EVEN = 1'b0;
  localparam logic PIPE_ODD  = 1'b1;

  typedef struct packed {
    logic             vld;
    logic             pipe;
    logic             regWriteEnable;
    logic             source;
    logic [3:0]       control;
    logic [REG_W-1:0] ra;
    logic [REG_W-1:0] rb;
    logic [REG_W-1:0] rc;
    logic [REG_W-1:0] rt;
    logic             use_ra;
    logic             use_rb;
    logic             use_rc;
    logic [6:0]       imm7;
    logic [9:0]       imm10;
    logic [15:0]      imm16;
    logic [17:0]      imm18;
    logic [LAT_W-1:0] lat;
  } dec_instr_t;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_PAIR   = 2'd1,
    ST_SECOND = 2'd2
  } state_e;

endpackage

// File: rtl/spu_scoreboard.sv
// spu_scoreboard: per-register countdown of cycles until a result may be consumed.
//   clk, reset          : clock, synchronous active-high reset (clears all counters)
//   ld0_* / ld1_*       : load ports for the two issue slots (slot 1 wins on a tie)
//   src0_addr/src1_addr : ra/rb/rc specifiers of slot 0 / slot 1 ([0]=ra,[1]=rb,[2]=rc)
//   rt0_addr/rt1_addr   : destination specifiers for the WAW checks
//   src*_busy, rt*_busy : counter for the addressed register is nonzero
module spu_scoreboard
  import spu_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ld0_en,
  input  logic [REG_W-1:0]      ld0_addr,
  input  logic [LAT_W-1:0]      ld0_lat,
  input  logic                  ld1_en,
  input  logic [REG_W-1:0]      ld1_addr,
  input  logic [LAT_W-1:0]      ld1_lat,
  input  logic [2:0][REG_W-1:0] src0_addr,
  input  logic [2:0][REG_W-1:0] src1_addr,
  input  logic [REG_W-1:0]      rt0_addr,
  input  logic [REG_W-1:0]      rt1_addr,
  output logic [2:0]            src0_busy,
  output logic [2:0]            src1_busy,
  output logic                  rt0_busy,
  output logic                  rt1_busy
);

  logic [LAT_W-1:0] cnt_q [NREG];
  logic [LAT_W-1:0] cnt_d [NREG];

  // The issue cycle counts as the first of lat cycles, so the stored value is
  // lat-1: a consumer sees zero exactly lat cycles after its producer issued.
  function automatic logic [LAT_W-1:0] load_val(input logic [LAT_W-1:0] lat);
    return (lat == '0) ? '0 : lat - LAT_W'(1);
  endfunction

  // Decrement every live counter; issue loads override the decrement.
  always_comb begin
    for (int i = 0; i < int'(NREG); i++) begin
      cnt_d[i] = (cnt_q[i] != '0) ? cnt_q[i] - LAT_W'(1) : cnt_q[i];
    end
    if (ld0_en) cnt_d[ld0_addr] = load_val(ld0_lat);
    if (ld1_en) cnt_d[ld1_addr] = load_val(ld1_lat);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NREG); i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NREG); i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Read ports.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      src0_busy[k] = (cnt_q[src0_addr[k]] != '0);
      src1_busy[k] = (cnt_q[src1_addr[k]] != '0);
    end
    rt0_busy = (cnt_q[rt0_addr] != '0);
    rt1_busy = (cnt_q[rt1_addr] != '0);
  end

endmodule

// File: rtl/spu_issue_ctrl.sv
// spu_issue_ctrl: dual-issue control stage in front of the ID/REG register.
//   clk, reset          : clock, synchronous active-high reset
//   in_valid / in_ready : decoder handshake for one instruction pair
//   in_instr0/in_instr1 : older / younger decoded instruction
//   flush               : drop buffered and incoming instructions this cycle
//   iss_instr_even/odd  : instruction issued to the even (_ID1) / odd (_ID2) pipe
//   iss_dual            : both slots issued this cycle
// Optional (SPU_ISSUE_STATS_EN): stall_cycles, dual_issue_cnt, single_issue_cnt.
module spu_issue_ctrl
  import spu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  dec_instr_t in_instr0,
  input  dec_instr_t in_instr1,
  input  logic       flush,
  output dec_instr_t iss_instr_even,
  output dec_instr_t iss_instr_odd,
  output logic       iss_dual
`ifdef SPU_ISSUE_STATS_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] dual_issue_cnt,
  output logic [31:0] single_issue_cnt
`endif
);

  state_e     state_q, state_d;
  dec_instr_t slot0_q, slot0_d;
  dec_instr_t slot1_q, slot1_d;

  logic [2:0] src0_busy, src1_busy;
  logic       rt0_busy, rt1_busy;
  logic       blk0, blk1, intra_dep;
  logic       issue0, issue1, drained, accept_ok;

  spu_scoreboard u_sb (
    .clk       (clk),
    .reset     (reset),
    .ld0_en    (issue0 && slot0_q.regWriteEnable),
    .ld0_addr  (slot0_q.rt),
    .ld0_lat   (slot0_q.lat),
    .ld1_en    (issue1 && slot1_q.regWriteEnable),
    .ld1_addr  (slot1_q.rt),
    .ld1_lat   (slot1_q.lat),
    .src0_addr ({slot0_q.rc, slot0_q.rb, slot0_q.ra}),
    .src1_addr ({slot1_q.rc, slot1_q.rb, slot1_q.ra}),
    .rt0_addr  (slot0_q.rt),
    .rt1_addr  (slot1_q.rt),
    .src0_busy (src0_busy),
    .src1_busy (src1_busy),
    .rt0_busy  (rt0_busy),
    .rt1_busy  (rt1_busy)
  );

  // Hazard resolution and issue decision for the buffered pair.
  always_comb begin
    blk0 = (slot0_q.use_ra && src0_busy[0]) || (slot0_q.use_rb && src0_busy[1]) ||
           (slot0_q.use_rc && src0_busy[2]) || (slot0_q.regWriteEnable && rt0_busy);
    blk1 = (slot1_q.use_ra && src1_busy[0]) || (slot1_q.use_rb && src1_busy[1]) ||
           (slot1_q.use_rc && src1_busy[2]) || (slot1_q.regWriteEnable && rt1_busy);
    // Dependences inside the pair are invisible to the scoreboard until slot 0 issues.
    intra_dep = (slot0_q.regWriteEnable &&
                 ((slot1_q.use_ra && (slot1_q.ra == slot0_q.rt)) ||
                  (slot1_q.use_rb && (slot1_q.rb == slot0_q.rt)) ||
                  (slot1_q.use_rc && (slot1_q.rc == slot0_q.rt)))) ||
                (slot0_q.regWriteEnable && slot1_q.regWriteEnable &&
                 (slot1_q.rt == slot0_q.rt));
    issue0  = 1'b0;
    issue1  = 1'b0;
    drained = 1'b0;
    unique case (state_q)
      ST_PAIR: begin
        issue0  = !blk0;
        issue1  = issue0 && slot1_q.vld && !blk1 &&
                  (slot0_q.pipe != slot1_q.pipe) && !intra_dep;
        // A pair whose younger slot is invalid drains with slot 0 alone.
        drained = issue0 && (issue1 || !slot1_q.vld);
      end
      ST_SECOND: begin
        issue1  = !blk1;
        drained = issue1;
      end
      default: drained = 1'b1;
    endcase
    if (flush) begin
      issue0 = 1'b0;
      issue1 = 1'b0;
    end
    accept_ok = !flush && drained;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      state_q <= state_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
    end
  end

  // Next-state: drain on issue, refill on accept, flush wins.
  always_comb begin
    state_d = state_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    unique case (state_q)
      ST_PAIR:   if (issue0) state_d = drained ? ST_EMPTY : ST_SECOND;
      ST_SECOND: if (issue1) state_d = ST_EMPTY;
      default:   state_d = ST_EMPTY;
    endcase
    if (in_valid && accept_ok) begin
      slot0_d = in_instr0;
      slot1_d = in_instr1;
      if (in_instr0.vld)      state_d = ST_PAIR;
      else if (in_instr1.vld) state_d = ST_SECOND;
      else                    state_d = ST_EMPTY;
    end
    if (flush) state_d = ST_EMPTY;
  end

  // Outputs: route each issued instruction by its pipe field, bubbles elsewhere.
  always_comb begin
    iss_instr_even = '0;
    iss_instr_odd  = '0;
    if (issue0) begin
      if (slot0_q.pipe == PIPE_ODD) iss_instr_odd  = slot0_q;
      else                          iss_instr_even = slot0_q;
    end
    if (issue1) begin
      if (slot1_q.pipe == PIPE_ODD) iss_instr_odd  = slot1_q;
      else                          iss_instr_even = slot1_q;
    end
    iss_dual = issue0 && issue1;
    in_ready = accept_ok;
  end

`ifdef SPU_ISSUE_STATS_EN
  logic [31:0] stall_q, stall_d, dual_q, dual_d, single_q, single_d;

  // Issue statistics; flush cycles are not counted.
  always_comb begin
    stall_d  = stall_q;
    dual_d   = dual_q;
    single_d = single_q;
    if (!flush) begin
      if ((state_q != ST_EMPTY) && !issue0 && !issue1) stall_d = stall_q + 32'd1;
      if (issue0 && issue1)                            dual_d  = dual_q + 32'd1;
      if (issue0 ^ issue1)                             single_d = single_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q  <= '0;
      dual_q   <= '0;
      single_q <= '0;
    end else begin
      stall_q  <= stall_d;
      dual_q   <= dual_d;
      single_q <= single_d;
    end
  end

  assign stall_cycles     = stall_q;
  assign dual_issue_cnt   = dual_q;
  assign single_issue_cnt = single_q;
`endif

endmodule

// File: tb/tb_spu_issue_ctrl.sv
// tb_spu_issue_ctrl: table-driven pairs plus flush / reset sequences; expected
// issues (tag, cycle, output side, dual flag) are queued when a pair is driven
// and matched by tag when the DUT presents an instruction.
module tb_spu_issue_ctrl;
  import spu_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  dec_instr_t in_instr0, in_instr1;
  logic       flush;
  dec_instr_t iss_instr_even, iss_instr_odd;
  logic       iss_dual;
`ifdef SPU_ISSUE_STATS_EN
  logic [31:0] stall_cycles, dual_issue_cnt, single_issue_cnt;
`endif

  spu_issue_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_instr0      (in_instr0),
    .in_instr1      (in_instr1),
    .flush          (flush),
    .iss_instr_even (iss_instr_even),
    .iss_instr_odd  (iss_instr_odd),
    .iss_dual       (iss_dual)
`ifdef SPU_ISSUE_STATS_EN
    ,
    .stall_cycles     (stall_cycles),
    .dual_issue_cnt   (dual_issue_cnt),
    .single_issue_cnt (single_issue_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    int          cyc;
    logic [15:0] tag;
    logic        side;
    logic        dual;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    dec_instr_t i0;
    dec_instr_t i1;
    int         d0;
    int         d1;
    logic       dual;
    int         gap;
  } vec_t;
  vec_t vecs[12];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_total++;
    if (act !== req) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    else n_pass++;
  endtask

  function automatic dec_instr_t mk(input int tag, input logic pipe, input logic we,
                                    input int rt, input int src, input logic [2:0] use_m,
                                    input int lat);
    dec_instr_t d;
    d = '0;
    d.vld = 1'b1;
    d.pipe = pipe;
    d.regWriteEnable = we;
    d.control = 4'(tag);
    d.rt = 7'(rt);
    d.ra = 7'(src);
    d.rb = 7'(src);
    d.rc = 7'(src);
    d.use_ra = use_m[0];
    d.use_rb = use_m[1];
    d.use_rc = use_m[2];
    d.imm16 = 16'(tag);
    d.lat = 4'(lat);
    return d;
  endfunction

  task automatic push_exp(input dec_instr_t i, input int when, input logic dual);
    exp_t e;
    e.cyc = when;
    e.tag = i.imm16;
    e.side = i.pipe;
    e.dual = dual;
    exp_q.push_back(e);
  endtask

  // Drive one pair for one cycle starting just after a rising edge; d0/d1 are
  // issue delays relative to the first cycle after acceptance (<0: never issues).
  task automatic send(input dec_instr_t i0, input dec_instr_t i1,
                      input int d0, input int d1, input logic dual);
    int base;
    in_valid = 1'b1;
    in_instr0 = i0;
    in_instr1 = i1;
    @(negedge clk);
    chk("in_ready_at_send", 128'(in_ready), 128'(1));
    base = cyc + 1;
    if (d0 >= 0 && i0.vld) push_exp(i0, base + d0, dual);
    if (d1 >= 0 && i1.vld) push_exp(i1, base + d1, dual);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_instr0 = '0;
    in_instr1 = '0;
  endtask

  task automatic mon_out(input dec_instr_t o, input logic side);
    int idx;
    exp_t e;
    if (o.vld) begin
      idx = -1;
      foreach (exp_q[k]) if (idx < 0 && exp_q[k].tag == o.imm16) idx = k;
      if (idx < 0) begin
        n_total++;
        $display("FAIL unexpected_issue: tag %0d on side %0d at cycle %0d, expected no issue",
                 o.imm16, side, cyc);
      end else begin
        e = exp_q[idx];
        exp_q.delete(idx);
        chk("issue_cycle", 128'(cyc), 128'(e.cyc));
        chk("issue_side", 128'(side), 128'(e.side));
        chk("issue_dual", 128'(iss_dual), 128'(e.dual));
      end
    end else begin
      chk("bubble_zero", 128'(o), 128'(0));
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      mon_out(iss_instr_even, PIPE_EVEN);
      mon_out(iss_instr_odd, PIPE_ODD);
      if (!iss_instr_even.vld && !iss_instr_odd.vld) chk("dual_when_idle", 128'(iss_dual), 128'(0));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    dec_instr_t nv;
    reset = 1'b1;
    in_valid = 1'b0;
    flush = 1'b0;
    in_instr0 = '0;
    in_instr1 = '0;

    // Stimulus table: {slot0, slot1, delay0, delay1, dual, idle gap}.
    vecs[0]  = '{mk(1, PIPE_EVEN, 1, 5, 0, 3'b000, 2), mk(2, PIPE_ODD, 1, 6, 0, 3'b000, 6), 0, 0, 1'b1, 8};
    vecs[1]  = '{mk(3, PIPE_EVEN, 1, 5, 0, 3'b000, 2), mk(4, PIPE_ODD, 0, 0, 5, 3'b001, 0), 0, 2, 1'b0, 8};
    vecs[2]  = '{mk(5, PIPE_EVEN, 1, 7, 0, 3'b000, 1), mk(6, PIPE_EVEN, 1, 8, 0, 3'b000, 1), 0, 1, 1'b0, 4};
    vecs[3]  = '{mk(7, PIPE_EVEN, 1, 9, 0, 3'b000, 6), '0, 0, -1, 1'b0, 0};
    vecs[4]  = '{mk(8, PIPE_ODD, 0, 0, 9, 3'b001, 0), '0, 5, -1, 1'b0, 8};
    vecs[5]  = '{mk(9, PIPE_EVEN, 1, 10, 0, 3'b000, 1), mk(10, PIPE_ODD, 1, 10, 0, 3'b000, 1), 0, 1, 1'b0, 4};
    vecs[6]  = '{mk(11, PIPE_EVEN, 1, 11, 0, 3'b000, 0), '0, 0, -1, 1'b0, 0};
    vecs[7]  = '{mk(12, PIPE_ODD, 0, 0, 11, 3'b001, 0), '0, 0, -1, 1'b0, 4};
    nv = mk(13, PIPE_ODD, 1, 14, 0, 3'b000, 3);
    vecs[8]  = '{'0, nv, -1, 0, 1'b0, 4};
    nv = mk(14, PIPE_EVEN, 1, 15, 0, 3'b000, 3);
    nv.vld = 1'b0;
    vecs[9]  = '{nv, nv, -1, -1, 1'b0, 2};
    vecs[10] = '{mk(15, PIPE_EVEN, 1, 20, 0, 3'b000, 4), '0, 0, -1, 1'b0, 0};
    vecs[11] = '{mk(16, PIPE_ODD, 1, 20, 0, 3'b000, 1), '0, 3, -1, 1'b0, 6};

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", 128'(in_ready), 128'(1));
    chk("reset_even", 128'(iss_instr_even), 128'(0));
    chk("reset_odd", 128'(iss_instr_odd), 128'(0));
    chk("reset_dual", 128'(iss_dual), 128'(0));
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      send(vecs[i].i0, vecs[i].i1, vecs[i].d0, vecs[i].d1, vecs[i].dual);
      repeat (vecs[i].gap) begin
        @(posedge clk);
        #1;
      end
    end

    // rc-only source dependence; ra/rb carry the same register but are unused.
    send(mk(17, PIPE_ODD, 1, 21, 0, 3'b000, 3), '0, 0, -1, 1'b0);
    send(mk(18, PIPE_EVEN, 0, 0, 21, 3'b100, 0), '0, 2, -1, 1'b0);
    repeat (6) begin @(posedge clk); #1; end

    // Flush while slot 0 is stalled on r13; countdown must continue through it.
    send(mk(30, PIPE_EVEN, 1, 13, 0, 3'b000, 6), '0, 0, -1, 1'b0);
    send(mk(31, PIPE_EVEN, 0, 0, 13, 3'b001, 0), mk(32, PIPE_ODD, 1, 40, 0, 3'b000, 1), -1, -1, 1'b0);
    @(posedge clk);
    #1;
    flush = 1'b1;
    in_valid = 1'b1;
    in_instr0 = mk(33, PIPE_EVEN, 1, 41, 0, 3'b000, 1);
    in_instr1 = mk(34, PIPE_ODD, 1, 42, 0, 3'b000, 1);
    @(negedge clk);
    chk("flush_in_ready", 128'(in_ready), 128'(0));
    chk("flush_even", 128'(iss_instr_even), 128'(0));
    chk("flush_odd", 128'(iss_instr_odd), 128'(0));
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    in_instr0 = '0;
    in_instr1 = '0;
    send(mk(35, PIPE_ODD, 0, 0, 13, 3'b001, 0), '0, 2, -1, 1'b0);
    repeat (6) begin @(posedge clk); #1; end

    // Reset while slot 1 waits in SECOND on r12 with cycles still outstanding.
    send(mk(40, PIPE_EVEN, 1, 12, 0, 3'b000, 6), mk(41, PIPE_ODD, 0, 0, 12, 3'b001, 0), 0, -1, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    send(mk(42, PIPE_ODD, 0, 0, 12, 3'b001, 0), '0, 0, -1, 1'b0);

    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("pending_issues", 128'(exp_q.size()), 128'(0));
    foreach (exp_q[k]) $display("FAIL missing_issue: tag %0d never issued, expected at cycle %0d",
                                exp_q[k].tag, exp_q[k].cyc);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
